// File: rtl/nios_td3_mem_loader.sv
// Packs an 8-bit valid/ready boot stream into little-endian 32-bit RAM writes at base_addr + n.
// Accepts 1 byte/cycle; each packed word is issued one cycle after its last byte; in_ready drops once all bytes are in.
module nios_td3_mem_loader #(
    parameter int ADDR_W = 15,
    parameter int LEN_W  = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length_bytes,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [31:0]       checksum,
    output logic [ADDR_W:0]   words_written,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    output logic              mem_clken
);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    localparam int MAX_W = (ADDR_W > LEN_W) ? ADDR_W : LEN_W;
    localparam int SUM_W = MAX_W + 2;

    state_t            state;
    logic [ADDR_W-1:0] base_q;
    logic [LEN_W-1:0]  remaining;
    logic [1:0]        lane;
    logic [31:0]       pack;

    logic [LEN_W:0]    len_plus3;
    logic [SUM_W-1:0]  end_word;
    logic              range_fault;
    logic              xfer;
    logic              last_byte;
    logic              word_full;
    logic              abort_hit;
    logic [31:0]       lane_word;
    logic [3:0]        lane_be;

    // End word is exclusive: base + ceil(len/4) may equal 2^ADDR_W but not exceed it.
    assign len_plus3   = {1'b0, length_bytes} + (LEN_W+1)'(3);
    assign end_word    = SUM_W'(base_addr) + SUM_W'(len_plus3 >> 2);
    assign range_fault = end_word > (SUM_W'(1) << ADDR_W);

    assign in_ready  = (state == LOAD) && (remaining != '0);
    assign xfer      = in_valid && in_ready;
    assign last_byte = (remaining == LEN_W'(1));
    assign word_full = (lane == 2'd3) || last_byte;
    // Once the final byte is in (or being taken), the load is complete and abort no longer applies.
    assign abort_hit = abort && (remaining != '0) && !(xfer && last_byte);
    assign lane_word = 32'(in_data) << {lane, 3'b000};
    assign mem_clken = 1'b1;

    always_comb begin
        lane_be = 4'b1111;
        case (lane)
            2'd0:    lane_be = 4'b0001;
            2'd1:    lane_be = 4'b0011;
            2'd2:    lane_be = 4'b0111;
            default: lane_be = 4'b1111;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            base_q         <= '0;
            remaining      <= '0;
            lane           <= '0;
            pack           <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            checksum       <= '0;
            words_written  <= '0;
            mem_address    <= '0;
            mem_byteenable <= '0;
            mem_chipselect <= 1'b0;
            mem_write      <= 1'b0;
            mem_writedata  <= '0;
        end else begin
            mem_write      <= 1'b0;
            mem_chipselect <= 1'b0;
            done           <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        base_q <= base_addr;
                        error  <= 1'b0;
                        if (length_bytes == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else if (range_fault) begin
                            state <= DONE;
                            done  <= 1'b1;
                            error <= 1'b1;
                        end else begin
                            state         <= LOAD;
                            busy          <= 1'b1;
                            remaining     <= length_bytes;
                            lane          <= '0;
                            pack          <= '0;
                            checksum      <= '0;
                            words_written <= '0;
                        end
                    end
                end
                LOAD: begin
                    // The final byte always produces a write, so remaining==0 marks that write cycle.
                    if (remaining == '0) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (abort_hit) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        error <= 1'b1;
                        pack  <= '0;
                        lane  <= '0;
                    end else if (xfer) begin
                        checksum  <= checksum + {24'd0, in_data};
                        remaining <= remaining - LEN_W'(1);
                        if (word_full) begin
                            mem_write      <= 1'b1;
                            mem_chipselect <= 1'b1;
                            mem_writedata  <= pack | lane_word;
                            mem_byteenable <= lane_be;
                            mem_address    <= base_q + words_written[ADDR_W-1:0];
                            words_written  <= words_written + (ADDR_W+1)'(1);
                            pack           <= '0;
                            lane           <= '0;
                        end else begin
                            pack <= pack | lane_word;
                            lane <= lane + 2'd1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
